// File: rtl/mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_unit
//  Description : Multi-cycle control and datapath sequencer for a 16-bit,
//                8-register RISC core. Fetches over a req/ready handshake,
//                sequences FETCH/DECODE/EXEC/MEM/WB/PCUPD, and commits the
//                next PC into R0 through the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_unit #(
    parameter int                DW       = 16,
    parameter logic [DW-1:0]     RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          proc_rst_n,
    // memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    // register file port
    output logic [2:0]    ra,
    output logic [2:0]    rb,
    output logic [2:0]    rc,
    output logic [DW-1:0] rc_data,
    output logic          reg_write,
    input  logic [DW-1:0] ra_data,
    input  logic [DW-1:0] rb_data,
    output logic          pc_write,
    output logic [DW-1:0] pc_in,
    // status
    output logic          halted
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_ADI  = 4'b0001;
    localparam logic [3:0] c_OP_NAND = 4'b0010;
    localparam logic [3:0] c_OP_LW   = 4'b0100;
    localparam logic [3:0] c_OP_SW   = 4'b0101;
    localparam logic [3:0] c_OP_BEQ  = 4'b1100;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    localparam logic [DW-1:0] c_ONE  = DW'(1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_PCUPD  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    // r_run is clear while in reset and sets on the first edge after
    // release, so FETCH drives no request until the core is really running.
    logic          r_run;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_mdr;
    logic [DW-1:0] r_next_pc;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [3:0]    w_op;
    logic [2:0]    w_fa;
    logic [2:0]    w_fb;
    logic [2:0]    w_fc;
    logic [DW-1:0] w_imm;
    logic [2:0]    w_dest;
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_next_pc;

    assign w_op  = r_ir[15:12];
    assign w_fa  = r_ir[11:9];
    assign w_fb  = r_ir[8:6];
    assign w_fc  = r_ir[5:3];
    assign w_imm = {{(DW-6){r_ir[5]}}, r_ir[5:0]};

    // Source addresses follow the latched instruction; the register file
    // reads combinationally and A/B are captured in DECODE.
    assign ra = w_fa;
    assign rb = w_fb;

    // Destination register selection per opcode (0 means no writeback)
    always_comb begin
        w_dest = 3'd0;
        case (w_op)
            c_OP_ADD,
            c_OP_NAND: w_dest = w_fc;
            c_OP_ADI:  w_dest = w_fb;
            c_OP_LW:   w_dest = w_fa;
            default:   w_dest = 3'd0;
        endcase
    end

    // ALU result, or effective address for loads/stores
    always_comb begin
        w_alu = r_a + r_b;
        case (w_op)
            c_OP_NAND: w_alu = ~(r_a & r_b);
            c_OP_ADI:  w_alu = r_a + w_imm;
            c_OP_LW,
            c_OP_SW:   w_alu = r_b + w_imm;
            default:   w_alu = r_a + r_b;
        endcase
    end

    // Branch target is relative to the address of the BEQ itself
    always_comb begin
        if ((w_op == c_OP_BEQ) && (r_a == r_b)) begin
            w_next_pc = r_pc + w_imm;
        end else begin
            w_next_pc = r_pc + c_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and all Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rc          = 3'd0;
        rc_data     = '0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_in       = '0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_run) begin
                    mem_req  = 1'b1;
                    mem_addr = r_pc;
                    if (mem_ready) begin
                        w_state_nxt = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    c_OP_LW,
                    c_OP_SW:   w_state_nxt = S_MEM;
                    c_OP_ADD,
                    c_OP_NAND,
                    c_OP_ADI:  w_state_nxt = S_WB;
                    c_OP_HALT: w_state_nxt = S_HALT;
                    default:   w_state_nxt = S_PCUPD;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_addr  = r_alu;
                mem_we    = (w_op == c_OP_SW);
                mem_wdata = r_a;
                if (mem_ready) begin
                    w_state_nxt = (w_op == c_OP_LW) ? S_WB : S_PCUPD;
                end
            end
            S_WB: begin
                rc          = w_dest;
                rc_data     = (w_op == c_OP_LW) ? r_mdr : r_alu;
                // R0 holds the PC; a data write to it is dropped
                reg_write   = (w_dest != 3'd0);
                w_state_nxt = S_PCUPD;
            end
            S_PCUPD: begin
                pc_write    = 1'b1;
                pc_in       = r_next_pc;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted      = 1'b1;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Datapath registers, each loaded in the state that produces its value
    always_ff @(posedge clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            r_run     <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_next_pc <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_run && mem_ready) begin
                        r_ir <= mem_rdata;
                    end
                end
                S_DECODE: begin
                    r_a <= ra_data;
                    r_b <= rb_data;
                end
                S_EXEC: begin
                    r_alu     <= w_alu;
                    r_next_pc <= w_next_pc;
                end
                S_MEM: begin
                    if (mem_ready && (w_op == c_OP_LW)) begin
                        r_mdr <= mem_rdata;
                    end
                end
                S_PCUPD: begin
                    r_pc <= r_next_pc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl_unit
//  Description : Directed self-checking bench for mc_ctrl_unit. A single
//                process models the memory responder and the register file
//                and walks through hand-computed instruction scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_unit;

    logic        clk;
    logic        proc_rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rc;
    logic [15:0] rc_data;
    logic        reg_write;
    logic [15:0] ra_data;
    logic [15:0] rb_data;
    logic        pc_write;
    logic [15:0] pc_in;
    logic        halted;

    mc_ctrl_unit #(
        .DW       (16),
        .RESET_PC (16'h0000)
    ) u_dut (
        .clk        (clk),
        .proc_rst_n (proc_rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ra         (ra),
        .rb         (rb),
        .rc         (rc),
        .rc_data    (rc_data),
        .reg_write  (reg_write),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .pc_write   (pc_write),
        .pc_in      (pc_in),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem  [0:65535];
    logic [15:0] regs [0:7];

    assign ra_data = regs[ra];
    assign rb_data = regs[rb];

    int n_run;
    int n_fail;
    int fetch_wait;
    int data_wait;
    int wcnt;
    int req_idx;

    // results of the last run_instr
    int          t_rw_cyc;
    logic [2:0]  t_rw_rc;
    logic [15:0] t_rw_data;
    int          t_pw_cyc;
    logic [15:0] t_pw_pc;
    int          t_d_cnt;
    logic [15:0] t_d_addr;
    logic        t_d_we;
    logic [15:0] t_d_wdata;
    logic        t_d_stable;
    int          t_h_cyc;
    logic        t_clash;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder and register-file update, evaluated mid-cycle
    task automatic respond();
        int lim;
        if (!proc_rst_n) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            req_idx   = 0;
        end else begin
            if (mem_req) begin
                lim = (req_idx == 0) ? fetch_wait : data_wait;
                if (wcnt >= lim) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    wcnt    = 0;
                    req_idx = req_idx + 1;
                end else begin
                    mem_ready = 1'b0;
                    wcnt      = wcnt + 1;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            if (reg_write) regs[rc] = rc_data;
            if (pc_write) begin
                regs[0] = pc_in;
                req_idx = 0;
            end
        end
    endtask

    // Advance to the sample point of the next cycle (2 ns after posedge)
    task automatic tick();
        @(negedge clk);
        respond();
        @(posedge clk);
        #2;
    endtask

    // Run one instruction from its FETCH cycle (cycle 1) to PCUPD or HALT
    task automatic run_instr();
        logic fetching;
        logic done;
        t_rw_cyc = 0; t_rw_rc = 3'd0; t_rw_data = 16'h0;
        t_pw_cyc = 0; t_pw_pc = 16'h0;
        t_d_cnt = 0; t_d_addr = 16'h0; t_d_we = 1'b0; t_d_wdata = 16'h0;
        t_d_stable = 1'b1; t_h_cyc = 0; t_clash = 1'b0;
        fetching = 1'b1;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            tick();
            if (fetching && !mem_req) begin
                fetching = 1'b0;
            end else if (!fetching && mem_req) begin
                if (t_d_cnt == 0) begin
                    t_d_addr = mem_addr; t_d_we = mem_we; t_d_wdata = mem_wdata;
                end else if (mem_addr !== t_d_addr || mem_we !== t_d_we || mem_wdata !== t_d_wdata) begin
                    t_d_stable = 1'b0;
                end
                t_d_cnt++;
            end
            if (reg_write && pc_write) t_clash = 1'b1;
            if (reg_write) begin
                t_rw_cyc = k; t_rw_rc = rc; t_rw_data = rc_data;
            end
            if (pc_write) begin
                t_pw_cyc = k; t_pw_pc = pc_in; done = 1'b1;
            end
            if (halted) begin
                t_h_cyc = k; done = 1'b1;
            end
        end
        chk("instr_completes", {31'd0, done}, 32'd1);
    endtask

    // Hold reset for two cycles, clear the register file
    task automatic apply_reset();
        proc_rst_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    endtask

    initial begin
        int bad;
        n_run = 0; n_fail = 0;
        fetch_wait = 0; data_wait = 0; wcnt = 0; req_idx = 0;
        mem_ready = 1'b0; mem_rdata = 16'h0;
        proc_rst_n = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;

        // ---------------- reset state ----------------
        apply_reset();
        chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_pc_write",  {31'd0, pc_write},  32'd0);
        chk("rst_halted",    {31'd0, halted},    32'd0);
        chk("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
        chk("rst_pc_in",     {16'd0, pc_in},     32'd0);

        // ---------------- group A: ALU ops, NOP, SW, HALT ----------------
        mem[0] = 16'h0298;  // ADD  R3 = R1 + R2
        mem[1] = 16'h22A0;  // NAND R4 = ~(R1 & R2)
        mem[2] = 16'h1205;  // ADI  R0 <- R1 + 5 (suppressed)
        mem[3] = 16'hA000;  // opcode 1010 -> NOP
        mem[4] = 16'h5410;  // SW   mem[R0 + 16] = R2
        mem[5] = 16'hF000;  // HALT
        regs[1] = 16'd3;
        regs[2] = 16'd4;
        proc_rst_n = 1'b1;

        run_instr();
        chk("add_rw_cyc",  t_rw_cyc,  32'd4);
        chk("add_rc",      {29'd0, t_rw_rc}, 32'd3);
        chk("add_rc_data", {16'd0, t_rw_data}, 32'h0007);
        chk("add_pw_cyc",  t_pw_cyc,  32'd5);
        chk("add_pc_in",   {16'd0, t_pw_pc}, 32'h0001);
        chk("add_excl",    {31'd0, t_clash}, 32'd0);

        run_instr();
        chk("nand_rc",      {29'd0, t_rw_rc}, 32'd4);
        chk("nand_rc_data", {16'd0, t_rw_data}, 32'hFFFF);
        chk("nand_pc_in",   {16'd0, t_pw_pc}, 32'h0002);

        run_instr();
        chk("adi_r0_no_rw", t_rw_cyc, 32'd0);
        chk("adi_pw_cyc",   t_pw_cyc, 32'd5);
        chk("adi_pc_in",    {16'd0, t_pw_pc}, 32'h0003);

        run_instr();
        chk("nop_pw_cyc", t_pw_cyc, 32'd4);
        chk("nop_pc_in",  {16'd0, t_pw_pc}, 32'h0004);
        chk("nop_no_rw",  t_rw_cyc, 32'd0);

        // R0 = 4 at this point, so the store goes to 20
        run_instr();
        chk("sw_d_cnt",   t_d_cnt, 32'd1);
        chk("sw_addr",    {16'd0, t_d_addr}, 32'h0014);
        chk("sw_we",      {31'd0, t_d_we}, 32'd1);
        chk("sw_wdata",   {16'd0, t_d_wdata}, 32'h0004);
        chk("sw_no_rw",   t_rw_cyc, 32'd0);
        chk("sw_pw_cyc",  t_pw_cyc, 32'd5);
        chk("sw_pc_in",   {16'd0, t_pw_pc}, 32'h0005);
        chk("sw_mem",     {16'd0, mem[20]}, 32'h0004);

        run_instr();
        chk("halt_cyc",   t_h_cyc, 32'd4);
        chk("halt_no_pw", t_pw_cyc, 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt_hold", bad, 32'd0);

        // ---------------- group B: LW with waits, reset mid-MEM ----------------
        apply_reset();
        mem[0] = 16'h4A7E;  // LW R5 = mem[R1 - 2]
        mem[1] = 16'h4A7E;
        mem[8] = 16'hBEEF;
        regs[1] = 16'd10;
        data_wait = 3;
        proc_rst_n = 1'b1;

        run_instr();
        chk("lw_d_cnt",   t_d_cnt, 32'd4);
        chk("lw_addr",    {16'd0, t_d_addr}, 32'h0008);
        chk("lw_we",      {31'd0, t_d_we}, 32'd0);
        chk("lw_stable",  {31'd0, t_d_stable}, 32'd1);
        chk("lw_rw_cyc",  t_rw_cyc, 32'd8);
        chk("lw_rc",      {29'd0, t_rw_rc}, 32'd5);
        chk("lw_rc_data", {16'd0, t_rw_data}, 32'hBEEF);
        chk("lw_pw_cyc",  t_pw_cyc, 32'd9);
        chk("lw_pc_in",   {16'd0, t_pw_pc}, 32'h0001);
        chk("lw_r5",      {16'd0, regs[5]}, 32'hBEEF);

        data_wait = 20;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("mid_mem_addr", {16'd0, mem_addr}, 32'h0008);
        proc_rst_n = 1'b0;
        #1;
        chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
        tick();
        tick();
        data_wait = 0;
        proc_rst_n = 1'b1;
        tick();
        chk("refetch_req",  {31'd0, mem_req}, 32'd1);
        chk("refetch_addr", {16'd0, mem_addr}, 32'h0000);

        // ---------------- group C: BEQ taken ----------------
        apply_reset();
        mem[0]  = 16'hC24A;  // BEQ R1,R1,+10
        mem[10] = 16'hC2BC;  // BEQ R1,R2,-4
        regs[1] = 16'd7;
        regs[2] = 16'd7;
        proc_rst_n = 1'b1;
        run_instr();
        chk("beq_fwd_pc_in", {16'd0, t_pw_pc}, 32'h000A);
        chk("beq_fwd_pw_cyc", t_pw_cyc, 32'd4);
        run_instr();
        chk("beq_eq_pc_in", {16'd0, t_pw_pc}, 32'h0006);
        chk("beq_eq_no_rw", t_rw_cyc, 32'd0);

        // ---------------- group D: BEQ not taken ----------------
        apply_reset();
        regs[1] = 16'd7;
        regs[2] = 16'd8;
        proc_rst_n = 1'b1;
        run_instr();
        run_instr();
        chk("beq_ne_pc_in", {16'd0, t_pw_pc}, 32'h000B);
        chk("beq_ne_no_rw", t_rw_cyc, 32'd0);
        chk("beq_ne_pw_cyc", t_pw_cyc, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
